// File: rtl/register_file_pkg.sv
// Shared sizing constants for the register file and its read ports.
package register_file_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/register_file_if.sv
// Register-file access bus: two read addresses, one write port, two read data outputs.
interface register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // No handshake: reads are combinational, a write commits on any falling clk edge with regWrite=1.
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic              regWrite;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] regA;
  logic [DATA_W-1:0] regB;

  modport master (
    output rs, rt, rd, regWrite, data,
    input  regA, regB
  );

  modport slave (
    input  rs, rt, rd, regWrite, data,
    output regA, regB
  );
endinterface

// File: rtl/regfile_read_port.sv
// Combinational read mux over the register array; address 0 always yields zero.
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int P_DATA_W = register_file_pkg::DATA_W,
  parameter int P_ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic [(2**P_ADDR_W)-1:0][P_DATA_W-1:0] i_regs,
  input  logic [P_ADDR_W-1:0]                    i_addr,
  output logic [P_DATA_W-1:0]                    o_data
);

  always_comb begin
    o_data = '0;
    if (i_addr != P_ADDR_W'(ZERO_REG)) begin
      o_data = i_regs[i_addr];
    end
  end

endmodule

// File: rtl/register_file.sv
// 32-entry register file: falling-edge writes, two combinational read ports, hardwired zero register.
module register_file
  import register_file_pkg::*;
#(
  parameter int P_DATA_W = register_file_pkg::DATA_W,
  parameter int P_ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  register_file_if.slave   bus
);

  localparam int LP_NREGS = 2**P_ADDR_W;

  logic [LP_NREGS-1:0][P_DATA_W-1:0] r_regs;
  logic                              w_we;

  assign w_we = bus.regWrite && (bus.rd != P_ADDR_W'(ZERO_REG));

  // Writing on the falling edge lets a same-cycle reader see the new value in the second half-cycle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else if (w_we) begin
      r_regs[bus.rd] <= bus.data;
    end
  end

  regfile_read_port #(
    .P_DATA_W (P_DATA_W),
    .P_ADDR_W (P_ADDR_W)
  ) u_read_a (
    .i_regs (r_regs),
    .i_addr (bus.rs),
    .o_data (bus.regA)
  );

  regfile_read_port #(
    .P_DATA_W (P_DATA_W),
    .P_ADDR_W (P_ADDR_W)
  ) u_read_b (
    .i_regs (r_regs),
    .i_addr (bus.rt),
    .o_data (bus.regB)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, writes, zero register, isolation, read-during-write.
module tb_register_file;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  register_file u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [4:0] addr, input logic [31:0] value);
    @(posedge clk);
    #1;
    bus.rd       = addr;
    bus.data     = value;
    bus.regWrite = 1'b1;
    @(negedge clk);
    #1;
    bus.regWrite = 1'b0;
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    bus.rs       = 5'd9;
    bus.rt       = 5'd16;
    bus.rd       = 5'd9;
    bus.data     = 32'hFFFF_FFFF;
    bus.regWrite = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.regA !== 32'h0) begin
      errors++;
      $display("FAIL reset_regA: got %h expected %h", bus.regA, 32'h0);
    end
    checks++;
    if (bus.regB !== 32'h0) begin
      errors++;
      $display("FAIL reset_regB: got %h expected %h", bus.regB, 32'h0);
    end
    @(posedge clk);
    #2;
    bus.regWrite = 1'b0;
    rst_n        = 1'b1;
    #1;
    checks++;
    if (bus.regA !== 32'h0) begin
      errors++;
      $display("FAIL reset_release_regA: got %h expected %h", bus.regA, 32'h0);
    end
  endtask

  task automatic test_write_read;
    do_write(5'd9, 32'hABCD_1234);
    bus.rs = 5'd9;
    bus.rt = 5'd9;
    #1;
    checks++;
    if (bus.regA !== 32'hABCD_1234) begin
      errors++;
      $display("FAIL write9_regA: got %h expected %h", bus.regA, 32'hABCD_1234);
    end
    checks++;
    if (bus.regB !== 32'hABCD_1234) begin
      errors++;
      $display("FAIL write9_regB: got %h expected %h", bus.regB, 32'hABCD_1234);
    end
  endtask

  task automatic test_zero_reg;
    do_write(5'd0, 32'hFFFF_FFFF);
    bus.rs = 5'd0;
    bus.rt = 5'd0;
    #1;
    checks++;
    if (bus.regA !== 32'h0) begin
      errors++;
      $display("FAIL zero_regA: got %h expected %h", bus.regA, 32'h0);
    end
    checks++;
    if (bus.regB !== 32'h0) begin
      errors++;
      $display("FAIL zero_regB: got %h expected %h", bus.regB, 32'h0);
    end
  endtask

  task automatic test_isolation;
    do_write(5'd16, 32'h1234_5678);
    bus.rs = 5'd16;
    bus.rt = 5'd9;
    #1;
    checks++;
    if (bus.regA !== 32'h1234_5678) begin
      errors++;
      $display("FAIL iso_reg16: got %h expected %h", bus.regA, 32'h1234_5678);
    end
    checks++;
    if (bus.regB !== 32'hABCD_1234) begin
      errors++;
      $display("FAIL iso_reg9: got %h expected %h", bus.regB, 32'hABCD_1234);
    end
  endtask

  task automatic test_no_write;
    @(posedge clk);
    #1;
    bus.rd       = 5'd9;
    bus.data     = 32'hDEAD_BEEF;
    bus.regWrite = 1'b0;
    @(negedge clk);
    #1;
    bus.rs = 5'd9;
    bus.rt = 5'd16;
    #1;
    checks++;
    if (bus.regA !== 32'hABCD_1234) begin
      errors++;
      $display("FAIL nowrite_reg9: got %h expected %h", bus.regA, 32'hABCD_1234);
    end
    checks++;
    if (bus.regB !== 32'h1234_5678) begin
      errors++;
      $display("FAIL nowrite_reg16: got %h expected %h", bus.regB, 32'h1234_5678);
    end
  endtask

  task automatic test_read_during_write;
    do_write(5'd5, 32'h0F0F_0F0F);
    @(posedge clk);
    #1;
    bus.rs       = 5'd5;
    bus.rt       = 5'd5;
    bus.rd       = 5'd5;
    bus.data     = 32'h5A5A_5A5A;
    bus.regWrite = 1'b1;
    #1;
    checks++;
    if (bus.regA !== 32'h0F0F_0F0F) begin
      errors++;
      $display("FAIL rdw_before: got %h expected %h", bus.regA, 32'h0F0F_0F0F);
    end
    @(negedge clk);
    #1;
    bus.regWrite = 1'b0;
    checks++;
    if (bus.regA !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL rdw_after_regA: got %h expected %h", bus.regA, 32'h5A5A_5A5A);
    end
    checks++;
    if (bus.regB !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL rdw_after_regB: got %h expected %h", bus.regB, 32'h5A5A_5A5A);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0]  addrs [4];
    logic [31:0] vals  [4];
    addrs = '{5'd1, 5'd2, 5'd30, 5'd31};
    vals  = '{32'h1111_1111, 32'h2222_2222, 32'hC0DE_0030, 32'h8000_0001};
    for (int i = 0; i < 4; i++) begin
      do_write(addrs[i], vals[i]);
    end
    for (int i = 0; i < 4; i++) begin
      bus.rs = addrs[i];
      bus.rt = 5'd5;
      #1;
      checks++;
      if (bus.regA !== vals[i]) begin
        errors++;
        $display("FAIL b2b_reg%0d: got %h expected %h", addrs[i], bus.regA, vals[i]);
      end
      checks++;
      if (bus.regB !== 32'h5A5A_5A5A) begin
        errors++;
        $display("FAIL b2b_reg5: got %h expected %h", bus.regB, 32'h5A5A_5A5A);
      end
    end
  endtask

  task automatic test_reset_mid;
    bus.rs = 5'd9;
    bus.rt = 5'd16;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.regA !== 32'h0) begin
      errors++;
      $display("FAIL midreset_regA: got %h expected %h", bus.regA, 32'h0);
    end
    checks++;
    if (bus.regB !== 32'h0) begin
      errors++;
      $display("FAIL midreset_regB: got %h expected %h", bus.regB, 32'h0);
    end
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.regA !== 32'h0) begin
      errors++;
      $display("FAIL postreset_regA: got %h expected %h", bus.regA, 32'h0);
    end
    checks++;
    if (bus.regB !== 32'h0) begin
      errors++;
      $display("FAIL postreset_regB: got %h expected %h", bus.regB, 32'h0);
    end
    do_write(5'd9, 32'hCAFE_F00D);
    bus.rt = 5'd5;
    #1;
    checks++;
    if (bus.regA !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL first_write_after_reset: got %h expected %h", bus.regA, 32'hCAFE_F00D);
    end
    checks++;
    if (bus.regB !== 32'h0) begin
      errors++;
      $display("FAIL reg5_cleared: got %h expected %h", bus.regB, 32'h0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_isolation();
    test_no_write();
    test_read_during_write();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32, register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; register count is 2**ADDR_W (32).
REQ-003 clk  input  1  single clock; register writes occur on its falling edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rs  input  ADDR_W  read-port A address.
REQ-006 rt  input  ADDR_W  read-port B address.
REQ-007 rd  input  ADDR_W  write address.
REQ-008 regWrite  input  1  write enable, active-high.
REQ-009 data  input  DATA_W  write data.
REQ-010 regA  output  DATA_W  contents of register rs.
REQ-011 regB  output  DATA_W  contents of register rt.

Function
REQ-012 The block SHALL hold 32 registers of DATA_W bits, indexed 0..31.
REQ-013 A write SHALL occur on the falling edge of clk when regWrite=1 and rd!=0, storing data into register rd.
REQ-014 When regWrite=0 on a falling edge, no register SHALL change.
REQ-015 Register 0 SHALL always read as zero, and writes addressed to it SHALL be discarded.
REQ-016 Reads SHALL be combinational: regA and regB SHALL follow rs, rt and register contents with zero clock latency.
REQ-017 Both read ports SHALL be independent; rs==rt SHALL return the same value on both ports.
REQ-018 Read-during-write to the same address SHALL return the old value before the falling edge and the new value after it, giving the first half-cycle write / second half-cycle read behaviour used by the pipeline.
REQ-019 No write bypass from the data port to the read ports beyond REQ-018 SHALL exist.
REQ-020 A write to register r SHALL leave every other register unchanged.

Reset
REQ-021 While rst_n=0, all 32 registers SHALL be cleared to zero asynchronously, independent of clk.
REQ-022 While rst_n=0, writes SHALL be ignored, and regA/regB SHALL read zero for any address.
REQ-023 After rst_n deasserts, the first write SHALL take effect on the next falling clk edge with regWrite=1.

Structure
REQ-024 A shared package SHALL hold DATA_W, ADDR_W, NUM_REGS=32 and the constant ZERO_REG=0.
REQ-025 The read port SHALL be a sub-module, regfile_read_port (address in, selected register out, zero for address 0), instantiated twice.
REQ-026 The storage array and write logic SHALL reside in register_file itself.

Verification
REQ-027 Write rd=9, data=0xABCD1234, regWrite=1 across a falling edge; then rs=rt=9 -> regA=regB=0xABCD1234.
REQ-028 Write rd=0, data=0xFFFFFFFF, regWrite=1 across a falling edge; then rs=rt=0 -> regA=regB=0x00000000.
REQ-029 Write rd=16, data=0x12345678; then rs=16, rt=9 -> regA=0x12345678, regB=0xABCD1234 (reg 9 unchanged).
REQ-030 Apply regWrite=0, rd=9, data=0xDEADBEEF across a falling edge -> reg 9 still reads 0xABCD1234.
REQ-031 Assert rst_n=0 mid-cycle, away from any clk edge -> regA/regB read 0 immediately for rs=9, rt=16, and still read 0 after rst_n=1 is released.
REQ-032 Hold rs=5 while writing rd=5, data=0x5A5A5A5A -> regA shows the old value before the falling edge and 0x5A5A5A5A after it.
